// File: rtl/frame_streamer_pkg.sv
// Shared definitions for the frame streamer: default geometry and FSM state encodings.
package frame_streamer_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 5;
  localparam int DEF_IMG_H  = 5;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_FETCH = 3'd1,
    FS_SEND  = 3'd2,
    FS_FLUSH = 3'd3,
    FS_DONE  = 3'd4
  } fs_state_t;

endpackage

// File: rtl/frame_addr_ctr.sv
// Pixel index counter for the frame streamer; flags the last pixel of the frame.
module frame_addr_ctr #(
  parameter int PIX_N = 25,
  parameter int CNT_W = $clog2(PIX_N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign last = (cnt_reg == CNT_W'(PIX_N - 1));

endmodule

// File: rtl/frame_streamer.sv
// Streams one frame from a synchronous frame RAM into the line-buffer Fifo,
// then pads with zeros until the Fifo reports done or the flush budget runs out.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int ADDR_W    = 8,
  parameter int MAX_FLUSH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              sink_idle,
  input  logic              sink_done,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_i,
  output logic              busy,
  output logic              frame_done,
  output logic              flush_err
);

  localparam int PIX_N = IMG_W * IMG_H;
  localparam int PIX_W = $clog2(PIX_N + 1);
  localparam int FL_W  = $clog2(MAX_FLUSH + 1);

  fs_state_t         state_reg, state_next;
  logic [DATA_W-1:0] pix_q_reg;
  logic              first_send_reg;
  logic [FL_W-1:0]   flush_cnt_reg;
  logic              data_valid_reg, busy_reg, frame_done_reg, flush_err_reg;
  logic [DATA_W-1:0] data_i_reg;

  logic              cnt_clr, cnt_inc, last_pix;
  logic              send_word, send_pad, set_err;
  logic [PIX_W-1:0]  pix_cnt;
  logic [DATA_W-1:0] pix_word;

  frame_addr_ctr #(
    .PIX_N (PIX_N),
    .CNT_W (PIX_W)
  ) u_addr_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (pix_cnt),
    .last  (last_pix)
  );

  assign mem_addr = ADDR_W'(pix_cnt);

  // RAM data is only guaranteed on the first SEND cycle; later cycles use the captured copy.
  assign pix_word = first_send_reg ? mem_data : pix_q_reg;

  always_comb begin
    state_next = state_reg;
    mem_rd_en  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    send_word  = 1'b0;
    send_pad   = 1'b0;
    set_err    = 1'b0;
    case (state_reg)
      FS_IDLE: begin
        if (start) begin
          cnt_clr    = 1'b1;
          state_next = FS_FETCH;
        end
      end
      FS_FETCH: begin
        mem_rd_en  = 1'b1;
        state_next = FS_SEND;
      end
      FS_SEND: begin
        if (sink_idle) begin
          send_word  = 1'b1;
          cnt_inc    = 1'b1;
          state_next = last_pix ? FS_FLUSH : FS_FETCH;
        end
      end
      FS_FLUSH: begin
        if (sink_done) begin
          state_next = FS_DONE;
        end else if (flush_cnt_reg == FL_W'(MAX_FLUSH)) begin
          set_err    = 1'b1;
          state_next = FS_DONE;
        end else if (sink_idle) begin
          send_pad = 1'b1;
        end
      end
      FS_DONE: begin
        state_next = FS_IDLE;
      end
      default: begin
        state_next = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= FS_IDLE;
      pix_q_reg      <= '0;
      first_send_reg <= 1'b0;
      flush_cnt_reg  <= '0;
      data_valid_reg <= 1'b0;
      data_i_reg     <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      flush_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      first_send_reg <= (state_reg == FS_FETCH);
      data_valid_reg <= send_word | send_pad;
      busy_reg       <= (state_next != FS_IDLE);
      frame_done_reg <= (state_reg == FS_DONE);
      if (first_send_reg) begin
        pix_q_reg <= mem_data;
      end
      if (send_word) begin
        data_i_reg <= pix_word;
      end else if (send_pad) begin
        data_i_reg <= '0;
      end
      if (send_pad) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end else if (state_reg == FS_DONE) begin
        flush_cnt_reg <= '0;
      end
      if (cnt_clr) begin
        flush_err_reg <= 1'b0;
      end else if (set_err) begin
        flush_err_reg <= 1'b1;
      end
    end
  end

  assign data_valid = data_valid_reg;
  assign data_i     = data_i_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign flush_err  = flush_err_reg;

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: expected pixels are queued at start, popped per data_valid.
module tb_frame_streamer;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int MAX_FLUSH = 16;
  localparam int PIX_N     = 25;

  logic              clk = 1'b0;
  logic              rst_n, start, sink_idle, sink_done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              data_valid, busy, frame_done, flush_err;
  logic [DATA_W-1:0] data_i;

  logic [DATA_W-1:0] ram [0:255];
  logic [DATA_W-1:0] exp_q [$];
  logic              idle_q;
  bit                idle_rand;
  int                assertions, failures;
  int                words, pads, pix_seen, frame_done_cnt;

  frame_streamer #(
    .DATA_W    (DATA_W),
    .IMG_W     (5),
    .IMG_H     (5),
    .ADDR_W    (ADDR_W),
    .MAX_FLUSH (MAX_FLUSH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .sink_idle  (sink_idle),
    .sink_done  (sink_done),
    .data_valid (data_valid),
    .data_i     (data_i),
    .busy       (busy),
    .frame_done (frame_done),
    .flush_err  (flush_err)
  );

  always #5 clk = ~clk;

  // Read data is garbage on cycles without a read strobe, so stale-data use shows up.
  always @(posedge clk) begin
    mem_data <= mem_rd_en ? ram[mem_addr] : DATA_W'($urandom);
    idle_q   <= sink_idle;
  end

  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      words++;
      assertions++;
      if (!idle_q) begin
        failures++;
        $display("FAIL valid_after_idle0: data_valid=1 while sink_idle was 0, required no word");
      end
      assertions++;
      if (exp_q.size() > 0) begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        pix_seen++;
        if (data_i !== e) begin
          failures++;
          $display("FAIL pixel_order: data_i=0x%02h required 0x%02h", data_i, e);
        end
      end else begin
        pads++;
        if (data_i !== '0) begin
          failures++;
          $display("FAIL pad_zero: data_i=0x%02h required 0x00", data_i);
        end
      end
      $display("word %0d data_i=0x%02h", words, data_i);
    end
    if (rst_n && frame_done) frame_done_cnt++;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
    sink_idle = idle_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_frame();
    for (int k = 0; k < PIX_N; k++) exp_q.push_back(DATA_W'(k + 1));
  endtask

  // done_mode: 0 = sink_done 3 cycles after first pad, 1 = never, 2 = held high throughout.
  task automatic run_frame(input int done_mode, output bit timed_out);
    int fd0, since;
    push_frame();
    pads = 0;
    since = 0;
    fd0 = frame_done_cnt;
    timed_out = 1'b1;
    cyc();
    start = 1'b1;
    sink_done = (done_mode == 2);
    cyc();
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      cyc();
      if (frame_done_cnt != fd0) begin
        timed_out = 1'b0;
        break;
      end
      if (done_mode == 0 && pads > 0) begin
        since++;
        if (since >= 3) sink_done = 1'b1;
      end
    end
    if (timed_out) $display("FAIL frame_timeout: frame_done not seen within 2000 cycles");
    sink_done = 1'b0;
    idle_rand = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    assertions += 5;
    if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", data_valid); end
    if (data_i !== '0)       begin failures++; $display("FAIL reset_data: got 0x%02h required 0x00", data_i); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", frame_done); end
    if (flush_err !== 1'b0)  begin failures++; $display("FAIL reset_err: got %b required 0", flush_err); end
    rst_n = 1'b1;
    cyc();
    $display("test_reset done");
  endtask

  task automatic check_frame_end(input string name, input int fd0, input bit to,
                                 input int pad_lo, input int pad_hi, input logic err_exp);
    assertions += 5;
    if (to !== 1'b0) begin failures++; $display("FAIL %s_timeout: timed_out=%b required 0", name, to); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL %s_pixels: %0d pixels missing required 0", name, exp_q.size()); end
    if (frame_done_cnt != fd0 + 1) begin failures++; $display("FAIL %s_done_pulses: got %0d required 1", name, frame_done_cnt - fd0); end
    if (pads < pad_lo || pads > pad_hi) begin failures++; $display("FAIL %s_pads: got %0d required %0d..%0d", name, pads, pad_lo, pad_hi); end
    if (flush_err !== err_exp) begin failures++; $display("FAIL %s_flush_err: got %b required %b", name, flush_err, err_exp); end
    exp_q.delete();
  endtask

  task automatic test_basic_frame();
    bit to;
    int fd0 = frame_done_cnt;
    run_frame(0, to);
    check_frame_end("basic", fd0, to, 1, MAX_FLUSH, 1'b0);
    $display("test_basic_frame done pads=%0d", pads);
  endtask

  task automatic test_backpressure();
    bit to;
    int fd0 = frame_done_cnt;
    idle_rand = 1'b1;
    run_frame(0, to);
    check_frame_end("backpressure", fd0, to, 1, MAX_FLUSH, 1'b0);
    $display("test_backpressure done pads=%0d", pads);
  endtask

  task automatic test_flush_timeout();
    bit to;
    int fd0 = frame_done_cnt;
    run_frame(1, to);
    check_frame_end("timeout", fd0, to, MAX_FLUSH, MAX_FLUSH, 1'b1);
    fd0 = frame_done_cnt;
    run_frame(0, to);
    check_frame_end("after_timeout", fd0, to, 1, MAX_FLUSH, 1'b0);
    $display("test_flush_timeout done");
  endtask

  task automatic test_start_while_busy();
    int fd0 = frame_done_cnt;
    bit to = 1'b1;
    bit to2;
    push_frame();
    pads = 0;
    sink_done = 1'b1;
    cyc();
    start = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      cyc();
      start = busy;
      if (frame_done_cnt != fd0) begin
        to = 1'b0;
        break;
      end
    end
    start = 1'b0;
    sink_done = 1'b0;
    repeat (5) cyc();
    assertions++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_restart: busy=%b required 0", busy); end
    check_frame_end("start_busy", fd0, to, 0, 0, 1'b0);
    fd0 = frame_done_cnt;
    run_frame(2, to2);
    check_frame_end("restart", fd0, to2, 0, 0, 1'b0);
    $display("test_start_while_busy done");
  endtask

  task automatic test_reset_mid_frame();
    bit to = 1'b1;
    bit to2;
    int fd0, w0;
    int ps0 = pix_seen;
    push_frame();
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (pix_seen >= ps0 + 10) begin
        to = 1'b0;
        break;
      end
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    assertions += 6;
    if (to !== 1'b0)         begin failures++; $display("FAIL midrst_wait: 10 words not seen, required 10"); end
    if (data_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b required 0", data_valid); end
    if (data_i !== '0)       begin failures++; $display("FAIL midrst_data: got 0x%02h required 0x00", data_i); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b required 0", frame_done); end
    if (flush_err !== 1'b0)  begin failures++; $display("FAIL midrst_err: got %b required 0", flush_err); end
    exp_q.delete();
    rst_n = 1'b1;
    w0 = words;
    repeat (6) cyc();
    assertions++;
    if (words != w0) begin failures++; $display("FAIL midrst_quiet: %0d words after reset required 0", words - w0); end
    fd0 = frame_done_cnt;
    run_frame(0, to2);
    check_frame_end("after_reset", fd0, to2, 1, MAX_FLUSH, 1'b0);
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_early_done();
    bit to;
    int fd0 = frame_done_cnt;
    run_frame(2, to);
    check_frame_end("early_done", fd0, to, 0, 0, 1'b0);
    $display("test_early_done done");
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ram[k] = (k < PIX_N) ? DATA_W'(k + 1) : 8'hEE;
    rst_n = 1'b0;
    start = 1'b0;
    sink_idle = 1'b1;
    sink_done = 1'b0;
    idle_rand = 1'b0;
    assertions = 0;
    failures = 0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_flush_timeout();
    test_start_while_busy();
    test_reset_mid_frame();
    test_early_done();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
